ssd1306_init_sequencer: RTL and testbench

- Walks the SSD1306 init ROM from address 0 to its end marker.
- Presents each entry as one byte on a valid/ready byte stream towards the SPI/I2C serializer.
- Started by a single pulse after power-up. Reports busy while running and pulses done when finished.
- Sits between the top-level power-up logic and the display link; the frame renderer takes the link once done fires.

---
 rtl/ssd1306_init_sequencer.sv | 146 ++++++++++++++
 tb/tb_ssd1306_init_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_init_sequencer.sv
// rtl/ssd1306_init_sequencer.sv - walks the SSD1306 init ROM and streams each entry as one byte
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   start           one-cycle run request, honoured only while idle
//   rom_address     ROM address (0..SIZE), rom_data / rom_last combinational replies
//   out_data/out_dc byte and data/command flag towards the serializer
//   out_valid/out_ready  byte handshake
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse when the sequence has finished
//
// Optional feature: SSD1306_INIT_DELAY_EN turns flag-bit words into wait entries
// of rom_data[7:0]*DELAY_UNIT cycles; all transmitted bytes are then commands.

module ssd1306_init_sequencer #(
    parameter int SIZE       = 32,
    parameter int DATA_WIDTH = 9,
    parameter int DELAY_UNIT = 1000,
    parameter int ADDR_W     = $clog2(SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  rom_last,
    output logic [7:0]            out_data,
    output logic                  out_dc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

`ifdef SSD1306_INIT_DELAY_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND, DELAY, DONE} state_t;
    localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

    // Address one past the last entry; reaching it ends the run even without a marker.
    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(SIZE);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data_n;
    logic              dc_n;
    logic              valid_n;
    logic              busy_n;
    logic              done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rom_address <= '0;
            out_data    <= '0;
            out_dc      <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SSD1306_INIT_DELAY_EN
            cnt         <= '0;
`endif
        end else begin
            state       <= state_n;
            rom_address <= addr_n;
            out_data    <= data_n;
            out_dc      <= dc_n;
            out_valid   <= valid_n;
            busy        <= busy_n;
            done        <= done_n;
`ifdef SSD1306_INIT_DELAY_EN
            cnt         <= cnt_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = rom_address;
        data_n  = out_data;
        dc_n    = out_dc;
        valid_n = out_valid;
        done_n  = 1'b0;
`ifdef SSD1306_INIT_DELAY_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    addr_n  = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (rom_last || rom_address == END_ADDR) begin
                    // done is raised on entry so it is visible during DONE, alongside busy.
                    done_n  = 1'b1;
                    state_n = DONE;
                end
`ifdef SSD1306_INIT_DELAY_EN
                else if (rom_data[8]) begin
                    cnt_n   = CNT_W'(rom_data[7:0]) * CNT_W'(DELAY_UNIT);
                    state_n = DELAY;
                end
`endif
                else begin
                    data_n  = rom_data[7:0];
`ifdef SSD1306_INIT_DELAY_EN
                    dc_n    = 1'b0;
`else
                    dc_n    = rom_data[8];
`endif
                    valid_n = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    addr_n  = rom_address + 1'b1;
                    state_n = FETCH;
                end
            end
`ifdef SSD1306_INIT_DELAY_EN
            DELAY: begin
                if (cnt == '0) begin
                    addr_n  = rom_address + 1'b1;
                    state_n = FETCH;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`endif
            DONE: begin
                addr_n  = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_ssd1306_init_sequencer.sv
// tb/tb_ssd1306_init_sequencer.sv - scoreboard bench for ssd1306_init_sequencer
module tb_ssd1306_init_sequencer;

    localparam int SIZE = 4;
    localparam int DU   = 4;
    localparam int AW   = $clog2(SIZE + 1);
`ifdef SSD1306_INIT_DELAY_EN
    localparam logic [8:0] LAST_WORD = 9'h08D;
`else
    localparam logic [8:0] LAST_WORD = 9'h18D;
`endif

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic [AW-1:0] rom_address;
    logic [8:0]    rom_data;
    logic          rom_last;
    logic [7:0]    out_data;
    logic          out_dc, out_valid, busy, done;

    logic [8:0] rom [0:SIZE];
    logic [8:0] basic [0:3];
    logic       rom_last_en;
    int         rom_last_at;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         addr;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, done_cyc = -1;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rom_data = (rom_address <= AW'(SIZE)) ? rom[rom_address] : 9'h0FF;
    assign rom_last = rom_last_en && (int'(rom_address) == rom_last_at);

    ssd1306_init_sequencer #(.SIZE(SIZE), .DATA_WIDTH(9), .DELAY_UNIT(DU)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_address(rom_address), .rom_data(rom_data), .rom_last(rom_last),
        .out_data(out_data), .out_dc(out_dc), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic exp_dc(input logic [8:0] w);
`ifdef SSD1306_INIT_DELAY_EN
        return 1'b0;
`else
        return w[8];
`endif
    endfunction

    task automatic push(input logic [8:0] w, input int addr, input int c);
        exp_t e;
        e.data = w[7:0];
        e.dc   = exp_dc(w);
        e.addr = addr;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Monitor: compares every presented byte against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (int'(rom_address) > SIZE) check("addr_bound", rom_address, SIZE);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte", out_data, -1);
                end else begin
                    check("byte_data", out_data, sb[0].data);
                    check("byte_dc", out_dc, sb[0].dc);
                    check("byte_addr", rom_address, sb[0].addr);
                    if (!prev_valid && sb[0].cyc >= 0) check("byte_cycle", cyc, sb[0].cyc);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_in_done", busy, 1);
            end
            prev_valid = out_valid;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_addr(input int a);
        int n = 0;
        while (!(out_valid && int'(rom_address) == a) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic wait_done;
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("wait_done_timeout", 0, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic load_basic;
        for (int i = 0; i < 4; i++) rom[i] = basic[i];
        rom[4] = 9'h0FF;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_dc"}, out_dc, 0);
        check({tag, "_addr"}, rom_address, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int p, d0;
        basic[0] = 9'h0AE;
        basic[1] = 9'h0D5;
        basic[2] = 9'h080;
        basic[3] = LAST_WORD;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        rom_last_en = 1'b1; rom_last_at = 4;
        load_basic();
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic run with fixed timing: bytes at +2,+4,+6,+8, done at +10.
        p = cyc;
        for (int i = 0; i < 4; i++) push(basic[i], i, p + 2 + 2 * i);
        d0 = done_cnt;
        pulse_start();
        wait_done();
        check("t1_done_cycle", done_cyc, p + 10);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_sb_empty", sb.size(), 0);
        tick();

        // Backpressure on the second byte.
        for (int i = 0; i < 4; i++) push(basic[i], i, -1);
        pulse_start();
        wait_valid_addr(1);
        out_ready = 1'b0;
        repeat (5) tick();
        check("bp_valid_held", out_valid, 1);
        check("bp_addr_held", rom_address, 1);
        out_ready = 1'b1;
        wait_done();
        check("bp_sb_empty", sb.size(), 0);
        tick();

        // start while busy is ignored.
        for (int i = 0; i < 4; i++) push(basic[i], i, -1);
        d0 = done_cnt;
        pulse_start();
        wait_valid_addr(2);
        pulse_start();
        wait_done();
        repeat (12) tick();
        check("sb_done_count", done_cnt - d0, 1);
        check("sb_busy_idle", busy, 0);
        check("sb_sb_empty", sb.size(), 0);

        // Reset during SEND of byte 2, then replay from address 0.
        push(basic[0], 0, -1);
        push(basic[1], 1, -1);
        pulse_start();
        wait_valid_addr(1);
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        check_idle_outputs("midreset");
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        p = cyc;
        for (int i = 0; i < 4; i++) push(basic[i], i, p + 2 + 2 * i);
        d0 = done_cnt;
        pulse_start();
        wait_done();
        check("replay_done_count", done_cnt - d0, 1);
        check("replay_sb_empty", sb.size(), 0);
        tick();

        // Early end marker at address 2: only two bytes.
        rom_last_at = 2;
        p = cyc;
        push(basic[0], 0, p + 2);
        push(basic[1], 1, p + 4);
        pulse_start();
        wait_done();
        check("marker2_done_cycle", done_cyc, p + 6);
        check("marker2_sb_empty", sb.size(), 0);
        tick();

        // No end marker: the SIZE guard stops after four bytes.
        rom_last_en = 1'b0;
        p = cyc;
        for (int i = 0; i < 4; i++) push(basic[i], i, p + 2 + 2 * i);
        pulse_start();
        wait_done();
        check("nomark_done_cycle", done_cyc, p + 10);
        check("nomark_sb_empty", sb.size(), 0);
        rom_last_en = 1'b1;
        rom_last_at = 4;
        tick();

`ifdef SSD1306_INIT_DELAY_EN
        // Delay entry 0x103: AF appears 3*DU+2 cycles later than back-to-back.
        rom[0] = 9'h0AE; rom[1] = 9'h103; rom[2] = 9'h0AF; rom[3] = 9'h000;
        rom_last_at = 3;
        p = cyc;
        push(9'h0AE, 0, p + 2);
        push(9'h0AF, 2, p + 4 + 3 * DU + 2);
        pulse_start();
        wait_done();
        check("delay3_done_cycle", done_cyc, p + 4 + 3 * DU + 2 + 2);
        check("delay3_sb_empty", sb.size(), 0);
        tick();

        // Delay count 0: a single DELAY cycle.
        rom[1] = 9'h100;
        p = cyc;
        push(9'h0AE, 0, p + 2);
        push(9'h0AF, 2, p + 6);
        pulse_start();
        wait_done();
        check("delay0_done_cycle", done_cyc, p + 8);
        check("delay0_sb_empty", sb.size(), 0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
